// File: rtl/mul_share_arbiter_if.sv
// Request/response handshake bundle between N_REQ requesters and the
// shared-multiplier arbiter. Operand and result lanes are packed per
// requester: slice i = [8*i+7:8*i].
interface mul_share_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*8-1:0] req_multiplicand;
    logic [N_REQ*8-1:0] req_multiplier;
    logic [N_REQ-1:0]   resp_valid;
    logic [N_REQ-1:0]   resp_ready;
    logic [15:0]        resp_result;
    logic               resp_err;

    // Requester side
    modport master (
        output req_valid, req_multiplicand, req_multiplier, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_err
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_multiplicand, req_multiplier, resp_ready,
        output req_ready, resp_valid, resp_result, resp_err
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: shares one external 8x8 sequential shift-add multiplier
// among N_REQ requesters with round-robin arbitration. The multiplier is
// held in reset while idle and released to start an operation; its {A,Q}
// output is captured on end_op and returned to the granted requester.
// Optional feature macro: MUL_ARB_TIMEOUT_EN adds a RUN-state watchdog that
// returns result 0 with resp_err=1 after TIMEOUT_CYC cycles without end_op.
module mul_share_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mul_share_arbiter_if.slave         bus,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       mul_rst,
    output logic [7:0]                 mul_multiplicand,
    output logic [7:0]                 mul_multiplier,
    input  logic [15:0]                mul_result,
    input  logic                       mul_end_op
);

    localparam int PW = $clog2(N_REQ);

    if (N_REQ < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("mul_share_arbiter: N_REQ must be >= 2 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]      grant_id_q, grant_id_d;
    logic               mul_rst_q, mul_rst_d;
    logic [7:0]         opb_q, opb_d;
    logic [7:0]         opq_q, opq_d;
    logic [15:0]        result_q, result_d;
    logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic               busy_q, busy_d;

    logic               win_found_s;
    logic [PW-1:0]      win_idx_s;
    logic [PW-1:0]      win_next_s;
    logic [PW:0]        cand_s;
    logic [PW:0]        next_sum_s;
    logic [7:0]         sel_b_s;
    logic [7:0]         sel_q_s;
    logic [N_REQ-1:0]   req_ready_s;
    logic               resp_fire_s;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]      to_cnt_q, to_cnt_d;
    logic               resp_err_q, resp_err_d;
    logic               expire_s;
`endif

    // One-hot decode of a requester index
    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
        onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin search: first valid requester starting at rr_ptr (scan backwards so the lowest offset wins)
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand_s = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (cand_s >= (PW+1)'(N_REQ)) begin
                cand_s = cand_s - (PW+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (bus.req_valid[cand_s[PW-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s[PW-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Pointer value after the winner, wrapping modulo N_REQ
    always_comb begin
        next_sum_s = {1'b0, win_idx_s} + {{PW{1'b0}}, 1'b1};
        if (next_sum_s >= (PW+1)'(N_REQ)) begin
            win_next_s = PW'(next_sum_s - (PW+1)'(N_REQ));
        end else begin
            win_next_s = next_sum_s[PW-1:0];
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        sel_b_s = 8'd0;
        sel_q_s = 8'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx_s == PW'(i)) begin
                sel_b_s = bus.req_multiplicand[8*i +: 8];
                sel_q_s = bus.req_multiplier[8*i +: 8];
            end else begin
                sel_b_s = sel_b_s;
            end
        end
    end

    // Combinational accept strobe: only the winner, only while idle
    always_comb begin
        req_ready_s = '0;
        if (state_q == ST_IDLE && win_found_s) begin
            req_ready_s = onehot(win_idx_s);
        end else begin
            req_ready_s = '0;
        end
    end

    assign resp_fire_s = (state_q == ST_RESP) && bus.resp_ready[grant_id_q];

`ifdef MUL_ARB_TIMEOUT_EN
    assign expire_s = (to_cnt_q == TW'(TIMEOUT_CYC - 1));
`endif

    // Next-state and next-output computation for the IDLE/RUN/RESP sequencer
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        mul_rst_d    = mul_rst_q;
        opb_d        = opb_q;
        opq_d        = opq_q;
        result_d     = result_q;
        resp_valid_d = resp_valid_q;
        busy_d       = busy_q;
`ifdef MUL_ARB_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        resp_err_d   = resp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    opb_d      = sel_b_s;
                    opq_d      = sel_q_s;
                    grant_id_d = win_idx_s;
                    rr_ptr_d   = win_next_s;
                    mul_rst_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_RUN;
`ifdef MUL_ARB_TIMEOUT_EN
                    to_cnt_d   = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // end_op takes priority over a simultaneous watchdog expiry
                if (mul_end_op) begin
                    result_d     = mul_result;
                    mul_rst_d    = 1'b1;
                    resp_valid_d = onehot(grant_id_q);
                    state_d      = ST_RESP;
`ifdef MUL_ARB_TIMEOUT_EN
                end else if (expire_s) begin
                    result_d     = 16'd0;
                    resp_err_d   = 1'b1;
                    mul_rst_d    = 1'b1;
                    resp_valid_d = onehot(grant_id_q);
                    state_d      = ST_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                    state_d  = ST_RUN;
                end
`else
                end else begin
                    state_d = ST_RUN;
                end
`endif
            end
            ST_RESP: begin
                if (resp_fire_s) begin
                    resp_valid_d = '0;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
`ifdef MUL_ARB_TIMEOUT_EN
                    resp_err_d   = 1'b0;
`endif
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                mul_rst_d    = 1'b1;
                resp_valid_d = '0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            mul_rst_q    <= 1'b1;
            opb_q        <= 8'd0;
            opq_q        <= 8'd0;
            result_q     <= 16'd0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            mul_rst_q    <= mul_rst_d;
            opb_q        <= opb_d;
            opq_q        <= opq_d;
            result_q     <= result_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

`ifdef MUL_ARB_TIMEOUT_EN
    // Watchdog counter and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            to_cnt_q   <= to_cnt_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign bus.resp_err = resp_err_q;
`else
    assign bus.resp_err = 1'b0;
`endif

    assign bus.req_ready    = req_ready_s;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_result  = result_q;
    assign grant_id         = grant_id_q;
    assign busy             = busy_q;
    assign mul_rst          = mul_rst_q;
    assign mul_multiplicand = opb_q;
    assign mul_multiplier   = opq_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter. Directed vectors carry
// hand-computed products; a behavioural multiplier model raises end_op
// 17 cycles after its reset is released.
module tb_mul_share_arbiter;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  grant_id;
    logic        busy, mul_rst, mul_end_op;
    logic [7:0]  mul_b, mul_q;
    logic [15:0] mul_result;
    logic        stall = 1'b0;
    logic [4:0]  mcnt = 5'd0;

    always #5 clk = ~clk;

    mul_share_arbiter_if #(.N_REQ(N)) bus ();

    mul_share_arbiter #(.N_REQ(N), .TIMEOUT_CYC(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .grant_id(grant_id), .busy(busy),
        .mul_rst(mul_rst), .mul_multiplicand(mul_b), .mul_multiplier(mul_q),
        .mul_result(mul_result), .mul_end_op(mul_end_op)
    );

    // Multiplier model: counts cycles out of reset, done after 17 counts
    always @(posedge clk) begin
        if (mul_rst) mcnt <= 5'd0;
        else if (mcnt != 5'd17) mcnt <= mcnt + 5'd1;
    end
    assign mul_end_op = !mul_rst && (mcnt == 5'd17) && !stall;
    assign mul_result = mul_end_op ? ({8'd0, mul_b} * {8'd0, mul_q}) : 16'hA5A5;

    typedef struct { int id; logic [7:0] b; logic [7:0] q; } vec_t;
    typedef struct { int id; logic [7:0] b; logic [7:0] q; logic [15:0] res; logic err; int lat; } exp_t;

    vec_t pend[$];
    exp_t exp_q[$];
    int   acc_cyc[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   chk_spacing = 1'b0;
    int   last_acc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic issue(input int id, input logic [7:0] b, input logic [7:0] q,
                         input logic [15:0] res, input logic err, input int lat);
        vec_t v;
        exp_t e;
        v.id = id; v.b = b; v.q = q;
        e.id = id; e.b = b; e.q = q; e.res = res; e.err = err; e.lat = lat;
        exp_q.push_back(e);
        pend.push_back(v);
    endtask

    task automatic check_reset_vals();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_resp_result", 32'(bus.resp_result), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mul_rst", 32'(mul_rst), 32'd1);
        chk("rst_mul_b", 32'(mul_b), 32'd0);
        chk("rst_mul_q", 32'(mul_q), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.req_valid = '0;
        pend.delete();
        repeat (2) @(posedge clk);
        #1;
        acc_cyc.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        bit done = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && pend.size() == 0 && !busy && bus.req_valid == '0) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, 32'(done), 32'd1);
    endtask

    // Requester driver and accept monitor
    initial begin : req_driver
        logic [N-1:0] acc;
        forever begin
            @(negedge clk);
            acc = '0;
            if (rst_n) begin
                acc = bus.req_ready & bus.req_valid;
                if (bus.req_ready != '0) begin
                    chk("req_ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
                    chk("req_ready_idle_only", 32'(busy), 32'd0);
                    chk("req_ready_has_valid", 32'(acc == bus.req_ready), 32'd1);
                    acc_cyc.push_back(cyc);
                    if (chk_spacing && last_acc >= 0) chk("accept_spacing", 32'(cyc - last_acc), 32'd20);
                    last_acc = cyc;
                end
            end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) bus.req_valid[i] = 1'b0;
                if (!bus.req_valid[i] && rst_n) begin
                    for (int k = 0; k < pend.size(); k++) begin
                        if (pend[k].id == i) begin
                            bus.req_multiplicand[8*i +: 8] = pend[k].b;
                            bus.req_multiplier[8*i +: 8]   = pend[k].q;
                            bus.req_valid[i] = 1'b1;
                            pend.delete(k);
                            break;
                        end
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response
    initial begin : resp_monitor
        bit       active = 1'b0;
        exp_t     cur;
        int       lat;
        logic [N-1:0] ex_v;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
            end else if (bus.resp_valid != '0) begin
                if (!active) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_resp: resp_valid=%b with empty scoreboard", bus.resp_valid);
                        cur.id = -1; cur.b = 8'd0; cur.q = 8'd0; cur.res = 16'd0; cur.err = 1'b0; cur.lat = 0;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    lat = (acc_cyc.size() > 0) ? cyc - acc_cyc.pop_front() : -1;
                    ex_v = 4'b0001 << cur.id;
                    chk("resp_valid_id", 32'(bus.resp_valid), 32'(ex_v));
                    chk("resp_grant_id", 32'(grant_id), 32'(cur.id));
                    chk("resp_result", 32'(bus.resp_result), 32'(cur.res));
                    chk("resp_err", 32'(bus.resp_err), 32'(cur.err));
                    chk("resp_latency", 32'(lat), 32'(cur.lat));
                    chk("held_multiplicand", 32'(mul_b), 32'(cur.b));
                    chk("held_multiplier", 32'(mul_q), 32'(cur.q));
                    active = 1'b1;
                end else begin
                    ex_v = 4'b0001 << cur.id;
                    chk("resp_valid_stable", 32'(bus.resp_valid), 32'(ex_v));
                    chk("resp_result_stable", 32'(bus.resp_result), 32'(cur.res));
                end
                if ((bus.resp_ready & bus.resp_valid) != '0) active = 1'b0;
            end else begin
                if (active) chk("resp_valid_held", 32'd0, 32'd1);
                active = 1'b0;
            end
        end
    end

    // Directed test sequence
    initial begin : main
        bit seen;
        bus.req_valid        = '0;
        bus.req_multiplicand = '0;
        bus.req_multiplier   = '0;
        bus.resp_ready       = '1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single request, basic product and latency
        issue(0, 8'd13, 8'd11, 16'd143, 1'b0, 19);
        wait_drain("drain_single", 100);

        // Four requesters from reset: grants 0,1,2,3,0 spaced 20 cycles
        do_reset();
        chk_spacing = 1'b1;
        last_acc = -1;
        issue(0, 8'd3,   8'd5,   16'd15,   1'b0, 19);
        issue(1, 8'd20,  8'd30,  16'd600,  1'b0, 19);
        issue(2, 8'd100, 8'd7,   16'd700,  1'b0, 19);
        issue(3, 8'd17,  8'd17,  16'd289,  1'b0, 19);
        issue(0, 8'd9,   8'd200, 16'd1800, 1'b0, 19);
        wait_drain("drain_round_robin", 200);
        chk_spacing = 1'b0;

        // Operand extremes, zero product keeps full latency
        issue(2, 8'd255, 8'd255, 16'd65025, 1'b0, 19);
        issue(2, 8'd0,   8'd200, 16'd0,     1'b0, 19);
        wait_drain("drain_extremes", 100);

        // Back-pressure: hold resp_ready[0] low 10 cycles with req1 waiting
        @(posedge clk); #1;
        bus.resp_ready = 4'b1110;
        issue(0, 8'd7, 8'd9, 16'd63, 1'b0, 19);
        issue(1, 8'd4, 8'd4, 16'd16, 1'b0, 19);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.resp_valid[0]) begin seen = 1'b1; break; end
        end
        chk("backpressure_resp_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("no_accept_in_resp", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.resp_ready = '1;
        wait_drain("drain_backpressure", 100);

        // Reset in the middle of an operation abandons it
        pend.push_back('{id: 3, b: 8'd5, q: 8'd6});
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready[3]) begin seen = 1'b1; break; end
        end
        chk("midreset_accept_seen", 32'(seen), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        repeat (2) @(posedge clk);
        #1;
        acc_cyc.delete();
        rst_n = 1'b1;
        issue(3, 8'd11, 8'd12, 16'd132, 1'b0, 19);
        wait_drain("drain_after_reset", 100);

`ifdef MUL_ARB_TIMEOUT_EN
        // Watchdog expiry with the multiplier stalled
        stall = 1'b1;
        issue(1, 8'd50, 8'd50, 16'd0, 1'b1, 33);
        wait_drain("drain_timeout", 200);
        stall = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    // Global time bound
    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: bench still running at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

endmodule
